// File: rtl/led_sequencer.sv
// ============================================================================
// Module   : led_sequencer
// Brief    : Button-controlled LED pattern sequencer with PWM dimming output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_sequencer #(
    parameter int CLK_FREQ  = 12000000,
    parameter int STEP_HZ   = 2,
    parameter int NUM_LEDS  = 4,
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 btn_mode,
    input  logic                 btn_speed,
    input  logic [PWM_WIDTH-1:0] duty,
    output logic [NUM_LEDS-1:0]  led,
    output logic [NUM_LEDS-1:0]  led_dim,
    output logic                 step,
    output logic [1:0]           mode,
    output logic [1:0]           speed
);

    localparam int STEP_CLKS = CLK_FREQ / STEP_HZ;
    localparam int DIV_W     = $clog2(STEP_CLKS);

    localparam logic [1:0] MODE_ROTATE_L = 2'd0;
    localparam logic [1:0] MODE_ROTATE_R = 2'd1;
    localparam logic [1:0] MODE_BOUNCE   = 2'd2;
    localparam logic [1:0] MODE_BINARY   = 2'd3;

    localparam logic [NUM_LEDS-1:0] PAT_LSB  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NUM_LEDS-1:0] PAT_MSB  = {1'b1, {(NUM_LEDS-1){1'b0}}};
    localparam logic [NUM_LEDS-1:0] PAT_ZERO = '0;

    logic [DIV_W-1:0]     div_q, div_d;
    logic [NUM_LEDS-1:0]  pat_q, pat_d;
    logic                 dir_up_q, dir_up_d;
    logic [1:0]           mode_q, mode_d;
    logic [1:0]           speed_q, speed_d;
    logic                 step_q, step_d;
    logic                 btn_mode_q, btn_speed_q;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0]  led_dim_q, led_dim_d;

    logic                 mode_ev;
    logic                 speed_ev;
    logic [31:0]          period;
    logic                 terminal;
    logic                 pwm_on;
    logic [NUM_LEDS-1:0]  adv_pat;
    logic                 adv_dir_up;

    function automatic logic [NUM_LEDS-1:0] init_pattern(input logic [1:0] m);
        case (m)
            MODE_ROTATE_R: init_pattern = PAT_MSB;
            MODE_BINARY:   init_pattern = PAT_ZERO;
            default:       init_pattern = PAT_LSB;
        endcase
    endfunction

    assign mode_ev  = btn_mode  & ~btn_mode_q;
    assign speed_ev = btn_speed & ~btn_speed_q;
    assign period   = 32'(STEP_CLKS) >> speed_q;
    assign terminal = ({{(32-DIV_W){1'b0}}, div_q} == (period - 32'd1));
    assign pwm_on   = (pwm_cnt_q < duty);

    // Pattern that the current mode moves to on its next step.
    always_comb begin
        adv_pat    = pat_q;
        adv_dir_up = dir_up_q;
        case (mode_q)
            MODE_ROTATE_L: adv_pat = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
            MODE_ROTATE_R: adv_pat = {pat_q[0], pat_q[NUM_LEDS-1:1]};
            MODE_BOUNCE: begin
                if (dir_up_q) begin
                    if (pat_q[NUM_LEDS-1]) begin
                        adv_pat    = pat_q >> 1;
                        adv_dir_up = 1'b0;
                    end else begin
                        adv_pat    = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        adv_pat    = pat_q << 1;
                        adv_dir_up = 1'b1;
                    end else begin
                        adv_pat    = pat_q >> 1;
                    end
                end
            end
            default: adv_pat = pat_q + PAT_LSB;
        endcase
    end

    // Button events pre-empt a coinciding terminal count.
    always_comb begin
        div_d     = div_q + 1'b1;
        pat_d     = pat_q;
        dir_up_d  = dir_up_q;
        mode_d    = mode_q;
        speed_d   = speed_q;
        step_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        led_dim_d = pat_q & {NUM_LEDS{pwm_on}};
        if (mode_ev || speed_ev) begin
            div_d = '0;
            if (mode_ev) begin
                mode_d   = mode_q + 2'd1;
                pat_d    = init_pattern(mode_q + 2'd1);
                dir_up_d = 1'b1;
            end
            if (speed_ev) begin
                speed_d = speed_q + 2'd1;
            end
        end else if (terminal) begin
            div_d    = '0;
            pat_d    = adv_pat;
            dir_up_d = adv_dir_up;
            step_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q       <= '0;
            pat_q       <= PAT_LSB;
            dir_up_q    <= 1'b1;
            mode_q      <= MODE_ROTATE_L;
            speed_q     <= 2'd0;
            step_q      <= 1'b0;
            btn_mode_q  <= 1'b1;
            btn_speed_q <= 1'b1;
            pwm_cnt_q   <= '0;
            led_dim_q   <= '0;
        end else begin
            div_q       <= div_d;
            pat_q       <= pat_d;
            dir_up_q    <= dir_up_d;
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            step_q      <= step_d;
            btn_mode_q  <= btn_mode;
            btn_speed_q <= btn_speed;
            pwm_cnt_q   <= pwm_cnt_d;
            led_dim_q   <= led_dim_d;
        end
    end

    assign led     = pat_q;
    assign led_dim = led_dim_q;
    assign step    = step_q;
    assign mode    = mode_q;
    assign speed   = speed_q;

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module   : tb_led_sequencer
// Brief    : Directed vector bench for led_sequencer (16 Hz clock, 4 LEDs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_sequencer;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         btn_mode = 1'b0;
    logic         btn_speed = 1'b0;
    logic [W-1:0] duty = '0;
    logic [N-1:0] led;
    logic [N-1:0] led_dim;
    logic         step;
    logic [1:0]   mode;
    logic [1:0]   speed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       bm;
        logic       bs;
        int         n;
        logic [3:0] led;
        logic       step;
        logic [1:0] mode;
        logic [1:0] speed;
    } vec_t;

    vec_t vecs[$];

    led_sequencer #(
        .CLK_FREQ (16),
        .STEP_HZ  (2),
        .NUM_LEDS (N),
        .PWM_WIDTH(W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_mode (btn_mode),
        .btn_speed(btn_speed),
        .duty     (duty),
        .led      (led),
        .led_dim  (led_dim),
        .step     (step),
        .mode     (mode),
        .speed    (speed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic bm, input logic bs, input int n, input logic [3:0] l,
                       input logic s, input logic [1:0] m, input logic [1:0] sp);
        vec_t v;
        v.bm = bm; v.bs = bs; v.n = n; v.led = l; v.step = s; v.mode = m; v.speed = sp;
        vecs.push_back(v);
    endtask

    task automatic check_state(input string tag, input int l, input int s,
                               input int m, input int sp);
        check({tag, ".led"},   int'(led),   l);
        check({tag, ".step"},  int'(step),  s);
        check({tag, ".mode"},  int'(mode),  m);
        check({tag, ".speed"}, int'(speed), sp);
    endtask

    initial begin
        int dvals[3];
        logic [N-1:0] prev;
        int on_cnt;
        int bad_cnt;

        // bm, bs, cycles, led, step, mode, speed
        add(0, 0, 7, 4'd1, 0, 2'd0, 2'd0);
        add(0, 0, 1, 4'd2, 1, 2'd0, 2'd0);
        add(0, 0, 1, 4'd2, 0, 2'd0, 2'd0);
        add(0, 0, 7, 4'd4, 1, 2'd0, 2'd0);
        add(0, 0, 8, 4'd8, 1, 2'd0, 2'd0);
        add(0, 0, 8, 4'd1, 1, 2'd0, 2'd0);
        add(0, 1, 1, 4'd1, 0, 2'd0, 2'd1);
        add(0, 0, 3, 4'd1, 0, 2'd0, 2'd1);
        add(0, 0, 1, 4'd2, 1, 2'd0, 2'd1);
        add(0, 0, 4, 4'd4, 1, 2'd0, 2'd1);
        add(0, 1, 1, 4'd4, 0, 2'd0, 2'd2);
        add(0, 0, 1, 4'd4, 0, 2'd0, 2'd2);
        add(0, 1, 1, 4'd4, 0, 2'd0, 2'd3);
        add(0, 0, 1, 4'd8, 1, 2'd0, 2'd3);
        add(0, 1, 1, 4'd8, 0, 2'd0, 2'd0);
        add(0, 0, 7, 4'd8, 0, 2'd0, 2'd0);
        add(0, 0, 1, 4'd1, 1, 2'd0, 2'd0);
        add(1, 0, 1, 4'd8, 0, 2'd1, 2'd0);
        add(0, 0, 1, 4'd8, 0, 2'd1, 2'd0);
        add(1, 0, 1, 4'd1, 0, 2'd2, 2'd0);
        add(0, 0, 7, 4'd1, 0, 2'd2, 2'd0);
        add(0, 0, 1, 4'd2, 1, 2'd2, 2'd0);
        add(0, 0, 8, 4'd4, 1, 2'd2, 2'd0);
        add(0, 0, 8, 4'd8, 1, 2'd2, 2'd0);
        add(0, 0, 8, 4'd4, 1, 2'd2, 2'd0);
        add(0, 0, 8, 4'd2, 1, 2'd2, 2'd0);
        add(0, 0, 8, 4'd1, 1, 2'd2, 2'd0);
        add(0, 0, 8, 4'd2, 1, 2'd2, 2'd0);
        add(1, 0, 1, 4'd0, 0, 2'd3, 2'd0);
        add(0, 0, 8, 4'd1, 1, 2'd3, 2'd0);

        // Reset state
        tick(2);
        check_state("reset", 1, 0, 0, 0);
        check("reset.led_dim", int'(led_dim), 0);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            btn_mode  = vecs[i].bm;
            btn_speed = vecs[i].bs;
            tick(vecs[i].n);
            check_state($sformatf("vec%0d", i), int'(vecs[i].led), int'(vecs[i].step),
                        int'(vecs[i].mode), int'(vecs[i].speed));
        end

        // Binary count continues 2..15 then wraps to 0
        for (int k = 2; k <= 16; k++) begin
            tick(8);
            check($sformatf("binary%0d.led", k), int'(led), k % 16);
            check($sformatf("binary%0d.step", k), int'(step), 1);
        end

        // Mode wraps back to rotate-left
        btn_mode = 1'b1;
        tick(1);
        check_state("mode_wrap", 1, 0, 0, 0);
        btn_mode = 1'b0;

        // PWM duty: count cycles where led_dim shows the previous cycle's pattern
        dvals[0] = 0; dvals[1] = 4; dvals[2] = 15;
        for (int d = 0; d < 3; d++) begin
            duty = W'(dvals[d]);
            tick(2);
            prev    = led;
            on_cnt  = 0;
            bad_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                tick(1);
                if (led_dim == prev && led_dim != '0) on_cnt++;
                else if (led_dim != '0) bad_cnt++;
                prev = led;
            end
            check($sformatf("duty%0d.on_cycles", dvals[d]), on_cnt, dvals[d]);
            check($sformatf("duty%0d.bad_cycles", dvals[d]), bad_cnt, 0);
        end

        // Both buttons on the terminal-count edge
        btn_mode = 1'b1;
        tick(1);
        check_state("pre_tc.press", 8, 0, 1, 0);
        btn_mode = 1'b0;
        tick(7);
        check_state("pre_tc.wait", 8, 0, 1, 0);
        btn_mode  = 1'b1;
        btn_speed = 1'b1;
        tick(1);
        check_state("both_on_tc", 1, 0, 2, 1);
        btn_mode  = 1'b0;
        btn_speed = 1'b0;
        tick(1);
        check_state("both_after1", 1, 0, 2, 1);
        tick(2);
        check_state("both_after3", 1, 0, 2, 1);
        tick(1);
        check_state("both_step", 2, 1, 2, 1);

        // Asynchronous reset mid-step, button held through release
        #3;
        rstn     = 1'b0;
        btn_mode = 1'b1;
        #1;
        check_state("async_reset", 1, 0, 0, 0);
        check("async_reset.led_dim", int'(led_dim), 0);
        tick(2);
        rstn = 1'b1;
        tick(3);
        check_state("held_btn", 1, 0, 0, 0);
        btn_mode = 1'b0;
        tick(1);
        check_state("held_release", 1, 0, 0, 0);
        btn_mode = 1'b1;
        tick(1);
        check_state("held_repress", 8, 0, 1, 0);
        btn_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
